// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decoder-side signals of the fetch unit
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, pc, pc_plus4,
        input  imem_valid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, pc, pc_plus4,
        output imem_valid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with redirect and stall
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DISCARD} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inflight_q, inflight_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        req;
    logic [31:0] target;

    assign target = {bus.redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= RESET_PC;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        req        = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (bus.redirect) fetch_pc_d = target;
            end
            FETCH: begin
                req = 1'b1;
                if (bus.redirect) begin
                    fetch_pc_d = target;
                    // Without a response the old request is still owed to us; drain it in DISCARD.
                    if (!bus.imem_valid) begin
                        inflight_d = fetch_pc_q;
                        state_d    = DISCARD;
                    end
                end else if (bus.imem_valid) begin
                    instr_d    = bus.imem_rdata;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    valid_d    = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.redirect) begin
                    fetch_pc_d = target;
                    valid_d    = 1'b0;
                    state_d    = FETCH;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                req = 1'b1;
                if (bus.redirect) fetch_pc_d = target;
                if (bus.imem_valid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = (state_q == DISCARD) ? inflight_q : fetch_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[6:0];
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus0();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u2 (.clk(clk), .rst(rst2), .bus(bus2));

    int vectors = 0;
    int miscompares = 0;
    exp_t exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int mem_lat = 0;
    int mem_budget = 0;
    int mcnt = 0;
    logic [31:0] held_addr = '0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    // memory model: mem_lat wait cycles, at most mem_budget responses
    always @(negedge clk) begin
        if (!bus0.imem_req) begin
            bus0.imem_valid = 1'b0;
            mcnt = 0;
        end else begin
            if (mcnt == 0) held_addr = bus0.imem_addr;
            else check("addr_stable", bus0.imem_addr, held_addr);
            if (mcnt >= mem_lat && mem_budget > 0) begin
                bus0.imem_valid = 1'b1;
                bus0.imem_rdata = mem_read(bus0.imem_addr);
                mem_budget--;
                mcnt = 0;
            end else begin
                bus0.imem_valid = 1'b0;
                mcnt++;
            end
        end
    end

    // monitor: every new issued instruction is matched against the scoreboard
    always @(negedge clk) begin
        if (bus0.instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr_pc", bus0.pc, 32'hXXXX_XXXX);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("instr", bus0.instr, e.instr);
                check("op", {25'd0, bus0.op}, {25'd0, e.instr[6:0]});
                check("pc", bus0.pc, e.pc);
                check("pc_plus4", bus0.pc_plus4, e.pc + 32'd4);
            end
        end
        prev_valid = bus0.instr_valid;
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst0 = 1'b0;
        bus0.stall = 1'b0;
        bus0.redirect = 1'b0;
        bus0.redirect_pc = '0;
        mem_budget = 0;
        mem_lat = lat;
        mem.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.instr = i;
        e.pc = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus0.instr_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, bus0.instr_valid, 1);
    endtask

    initial begin
        bus0.imem_valid = 1'b0;
        bus0.imem_rdata = '0;
        bus2.imem_valid = 1'b0;
        bus2.imem_rdata = '0;
        bus2.stall = 1'b0;
        bus2.redirect = 1'b0;
        bus2.redirect_pc = '0;
        #1 rst2 = 1'b0;

        // reset values, then zero-wait lw at 0
        do_reset(0);
        check("rst_req", bus0.imem_req, 0);
        check("rst_addr", bus0.imem_addr, 32'h0);
        check("rst_valid", bus0.instr_valid, 0);
        check("rst_instr", bus0.instr, 32'h0000_0013);
        check("rst_op", {25'd0, bus0.op}, 32'h13);
        check("rst_pc", bus0.pc, 32'h0);
        check("rst_pc4", bus0.pc_plus4, 32'h4);
        mem[32'h0] = 32'h0000_2083;
        push(32'h0000_2083, 32'h0);
        mem_budget = 1;
        rst0 = 1'b1;
        @(negedge clk);
        check("first_req", bus0.imem_req, 1);
        check("first_addr", bus0.imem_addr, 32'h0);
        wait_empty("lw_done");
        check("lw_op", {25'd0, bus0.op}, 32'h03);

        // three sequential fetches with two wait cycles
        do_reset(2);
        mem[32'h0] = 32'h0011_2023;
        mem[32'h4] = 32'h0020_81B3;
        mem[32'h8] = 32'h0080_006F;
        push(32'h0011_2023, 32'h0);
        push(32'h0020_81B3, 32'h4);
        push(32'h0080_006F, 32'h8);
        mem_budget = 3;
        rst0 = 1'b1;
        wait_empty("seq3_done");

        // five stall cycles in ISSUE
        do_reset(1);
        mem[32'h0] = 32'h0000_0293;
        push(32'h0000_0293, 32'h0);
        mem_budget = 1;
        bus0.stall = 1'b1;
        rst0 = 1'b1;
        wait_valid("stall_reach");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus0.instr_valid, 1);
            check("stall_instr", bus0.instr, 32'h0000_0293);
            check("stall_pc", bus0.pc, 32'h0);
            check("stall_req", bus0.imem_req, 0);
            @(negedge clk);
        end
        bus0.stall = 1'b0;
        @(negedge clk);
        check("unstall_valid", bus0.instr_valid, 0);

        // redirect while a fetch is pending: stale response dropped
        do_reset(3);
        mem[32'h0] = 32'hDEAD_BEEF;
        mem[32'h100] = 32'h0050_0093;
        push(32'h0050_0093, 32'h100);
        mem_budget = 2;
        rst0 = 1'b1;
        @(negedge clk);
        check("pend_req", bus0.imem_req, 1);
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0103;
        @(negedge clk);
        bus0.redirect = 1'b0;
        check("discard_req", bus0.imem_req, 1);
        check("discard_addr", bus0.imem_addr, 32'h0);
        begin
            int n = 0;
            while (bus0.imem_addr != 32'h100 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("redir_addr", bus0.imem_addr, 32'h100);
        end
        wait_empty("redir_done");

        // redirect during a stall in ISSUE
        do_reset(0);
        mem[32'h0] = 32'h0010_0113;
        mem[32'h40] = 32'h0020_0193;
        push(32'h0010_0113, 32'h0);
        push(32'h0020_0193, 32'h40);
        mem_budget = 2;
        bus0.stall = 1'b1;
        rst0 = 1'b1;
        wait_valid("rs_reach");
        bus0.redirect = 1'b1;
        bus0.redirect_pc = 32'h0000_0040;
        @(negedge clk);
        bus0.redirect = 1'b0;
        check("rs_valid", bus0.instr_valid, 0);
        check("rs_req", bus0.imem_req, 1);
        check("rs_addr", bus0.imem_addr, 32'h40);
        wait_empty("rs_done");
        bus0.stall = 1'b0;

        // RESET_PC at the top of the address space
        @(negedge clk);
        check("w_rst_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        check("w_rst_pc4", bus2.pc_plus4, 32'h0);
        rst2 = 1'b1;
        @(negedge clk);
        check("w_req", bus2.imem_req, 1);
        check("w_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_valid = 1'b1;
        bus2.imem_rdata = 32'h0000_0093;
        @(negedge clk);
        bus2.imem_valid = 1'b0;
        check("w_valid", bus2.instr_valid, 1);
        check("w_pc", bus2.pc, 32'hFFFF_FFFC);
        check("w_pc4", bus2.pc_plus4, 32'h0);
        @(negedge clk);
        check("w_wrap_req", bus2.imem_req, 1);
        check("w_wrap_addr", bus2.imem_addr, 32'h0);
        #2 rst2 = 1'b0;
        #1;
        check("a_req", bus2.imem_req, 0);
        check("a_addr", bus2.imem_addr, 32'hFFFF_FFFC);
        check("a_valid", bus2.instr_valid, 0);
        check("a_instr", bus2.instr, 32'h0000_0013);
        check("a_op", {25'd0, bus2.op}, 32'h13);
        check("a_pc", bus2.pc, 32'hFFFF_FFFC);
        check("a_pc4", bus2.pc_plus4, 32'h0);

        @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
